// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : audio_pkg
//  Description: Shared audio definitions for the I2S playback path. Holds the
//               default sample/slot geometry, the stereo pair record and the
//               transmitter state encoding.
//  Revision   : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int c_DEF_SAMPLE_W  = 16;   // bits per channel sample
    localparam int c_DEF_SLOT_BITS = 32;   // bck periods per channel slot
    localparam int c_DEF_UCNT_W    = 16;   // underrun counter width

    typedef struct packed {
        logic [c_DEF_SAMPLE_W-1:0] l;
        logic [c_DEF_SAMPLE_W-1:0] r;
    } stereo_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } i2s_state_t;

endpackage : audio_pkg
`default_nettype wire

// File: rtl/i2s_tx_ctrl_buf.sv
`default_nettype none
// ============================================================================
//  Module     : i2s_sample_buf
//  Description: One-deep holding register for a stereo pair with a
//               valid/ready push side and a pop strobe issued at each frame
//               boundary. When the register is empty and a push lands in the
//               pop cycle, the incoming pair bypasses the register.
//  Revision   : 1.0 - initial release
//
//  Ports
//    clk           in   system clock
//    reset         in   synchronous, active-high
//    i_push_valid  in   producer has a pair
//    i_push_data   in   {left, right} pair
//    o_push_ready  out  holding register empty
//    i_pop         in   frame boundary: hand a pair to the serialiser
//    o_pop_hit     out  a pair is available this cycle (held or bypassed)
//    o_pop_data    out  pair handed out on a pop
// ============================================================================
module i2s_sample_buf
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = c_DEF_SAMPLE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push_valid,
    input  logic [2*SAMPLE_W-1:0] i_push_data,
    output logic                  o_push_ready,
    input  logic                  i_pop,
    output logic                  o_pop_hit,
    output logic [2*SAMPLE_W-1:0] o_pop_data
);

    logic                  r_held_valid;
    logic [2*SAMPLE_W-1:0] r_held_data;
    logic                  w_accept;

    assign o_push_ready = ~r_held_valid;
    assign w_accept     = i_push_valid & ~r_held_valid;

    // A held pair always wins; otherwise the pair being accepted right now
    // is passed straight through (bypass path).
    assign o_pop_hit  = r_held_valid | w_accept;
    assign o_pop_data = r_held_valid ? r_held_data : i_push_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_held_valid <= 1'b0;
            r_held_data  <= '0;
        end else if (i_pop) begin
            // Either the held pair leaves, or a same-cycle push bypassed it;
            // in both cases the register ends up empty.
            r_held_valid <= 1'b0;
            r_held_data  <= '0;
        end else if (w_accept) begin
            r_held_valid <= 1'b1;
            r_held_data  <= i_push_data;
        end
    end

endmodule : i2s_sample_buf
`default_nettype wire

// File: rtl/i2s_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : i2s_tx_ctrl
//  Description: I2S stereo transmitter sequencer in the clk domain. Detects
//               bck falling edges, runs the frame bit counter, generates lrck
//               and the MSB-first serial data with the I2S one-bit delay, and
//               fetches one stereo pair per frame from a one-deep buffer.
//  Revision   : 1.0 - initial release
//
//  Ports
//    clk           in   system clock
//    reset         in   synchronous, active-high
//    bck           in   bit clock, synchronous to clk
//    enable        in   run playback
//    sample_valid  in   upstream pair valid
//    sample_l/_r   in   left/right sample, two's complement
//    sample_ready  out  holding register empty
//    lrck          out  word select, 0 = left, 1 = right
//    sdata         out  serial data to the DAC
//    frame_start   out  1-clk pulse at each frame boundary
//    underrun      out  1-clk pulse: frame started with no pair available
//    underrun_cnt  out  saturating underrun count
// ============================================================================
module i2s_tx_ctrl
    import audio_pkg::*;
#(
    parameter int SAMPLE_W  = c_DEF_SAMPLE_W,
    parameter int SLOT_BITS = c_DEF_SLOT_BITS,
    parameter int UCNT_W    = c_DEF_UCNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                bck,
    input  logic                enable,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    output logic                sample_ready,
    output logic                lrck,
    output logic                sdata,
    output logic                frame_start,
    output logic                underrun,
    output logic [UCNT_W-1:0]   underrun_cnt
);

    localparam int                 c_CNT_W    = $clog2(2 * SLOT_BITS);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(2 * SLOT_BITS - 1);
    localparam logic [c_CNT_W-1:0] c_SLOT     = c_CNT_W'(SLOT_BITS);

    // The slot must hold the delay bit plus the whole sample.
    generate
        if (SLOT_BITS < SAMPLE_W + 1) begin : g_bad_slot_bits
            $error("i2s_tx_ctrl: SLOT_BITS must be >= SAMPLE_W+1");
        end
    endgenerate

    i2s_state_t            r_state;
    i2s_state_t            w_state_nxt;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic [c_CNT_W-1:0]    w_bit_cnt_nxt;
    logic                  w_boundary;

    logic                  r_bck_q;
    logic                  w_bck_fall;

    logic [SAMPLE_W-1:0]   r_cur_l;
    logic [SAMPLE_W-1:0]   r_cur_r;
    logic                  w_pop_hit;
    logic [2*SAMPLE_W-1:0] w_pop_data;

    logic                  w_slot_r;
    logic [c_CNT_W-1:0]    w_pos;
    logic [SAMPLE_W-1:0]   w_word;
    logic                  w_sbit;

    logic                  r_lrck;
    logic                  r_sdata;
    logic                  r_underrun;
    logic [UCNT_W-1:0]     r_ucnt;

    // ------------------------------------------------------------------
    // bck falling-edge detect
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bck_q <= 1'b0;
        end else begin
            r_bck_q <= bck;
        end
    end

    assign w_bck_fall = r_bck_q & ~bck;

    // ------------------------------------------------------------------
    // Frame FSM and bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_boundary    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_bck_fall && enable) begin
                    w_state_nxt   = RUN;
                    w_bit_cnt_nxt = '0;
                    w_boundary    = 1'b1;
                end
            end
            RUN: begin
                if (w_bck_fall) begin
                    if (r_bit_cnt == c_CNT_LAST) begin
                        w_bit_cnt_nxt = '0;
                        // Enable is only looked at on the wrap, so a
                        // mid-frame deassert still finishes the frame.
                        if (enable) begin
                            w_boundary = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + c_CNT_W'(1);
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stereo pair buffer
    // ------------------------------------------------------------------
    i2s_sample_buf #(
        .SAMPLE_W     (SAMPLE_W)
    ) u_buf (
        .clk          (clk),
        .reset        (reset),
        .i_push_valid (sample_valid),
        .i_push_data  ({sample_l, sample_r}),
        .o_push_ready (sample_ready),
        .i_pop        (w_boundary),
        .o_pop_hit    (w_pop_hit),
        .o_pop_data   (w_pop_data)
    );

    // Current frame's pair, plus underrun bookkeeping. A boundary with no
    // pair available plays a mute frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur_l    <= '0;
            r_cur_r    <= '0;
            r_underrun <= 1'b0;
            r_ucnt     <= '0;
        end else begin
            r_underrun <= w_boundary & ~w_pop_hit;
            if (w_boundary) begin
                if (w_pop_hit) begin
                    r_cur_l <= w_pop_data[2*SAMPLE_W-1:SAMPLE_W];
                    r_cur_r <= w_pop_data[SAMPLE_W-1:0];
                end else begin
                    r_cur_l <= '0;
                    r_cur_r <= '0;
                    if (r_ucnt != {UCNT_W{1'b1}}) begin
                        r_ucnt <= r_ucnt + UCNT_W'(1);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Serialiser: slot position 0 is the I2S delay bit, positions
    // 1..SAMPLE_W carry the sample MSB first, the rest of the slot is 0.
    // ------------------------------------------------------------------
    always_comb begin
        w_slot_r = (r_bit_cnt >= c_SLOT);
        w_pos    = w_slot_r ? (r_bit_cnt - c_SLOT) : r_bit_cnt;
        w_word   = w_slot_r ? r_cur_r : r_cur_l;
        w_sbit   = 1'b0;
        for (int i = 0; i < SAMPLE_W; i++) begin
            if (w_pos == c_CNT_W'(SAMPLE_W - i)) begin
                w_sbit = w_word[i];
            end
        end
    end

    // Pins are registered from the counter, so they move one clk after the
    // counter does (two clk after bck falls).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lrck  <= 1'b0;
            r_sdata <= 1'b0;
        end else begin
            r_lrck  <= (r_state == RUN) & w_slot_r;
            r_sdata <= (r_state == RUN) & w_sbit;
        end
    end

    assign lrck         = r_lrck;
    assign sdata        = r_sdata;
    assign frame_start  = w_boundary;
    assign underrun     = r_underrun;
    assign underrun_cnt = r_ucnt;

endmodule : i2s_tx_ctrl
`default_nettype wire

// File: tb/tb_i2s_tx_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module     : tb_i2s_tx_ctrl
//  Description: Self-checking bench for i2s_tx_ctrl. A reference model tracks
//               bck edges, frame boundaries, buffer occupancy and underruns;
//               accepted pairs go into a scoreboard queue and are compared
//               against whole frames captured on bck rising edges.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_i2s_tx_ctrl;
    import audio_pkg::*;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [63:0] exp_frame;   // sdata stream p0..p63, p0 in the MSB
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_l = '0;
    logic [15:0] sample_r = '0;
    logic [2:0]  r_div = '0;
    logic        bck;

    logic        sample_ready, lrck, sdata, frame_start, underrun;
    logic [15:0] underrun_cnt;
    logic        ready2, lrck2, sdata2, fs2, ur2;
    logic [1:0]  ucnt2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic        m_prev_bck = 1'b0;
    logic        m_run = 1'b0;
    int          m_cnt = 0;
    logic        m_held = 1'b0;
    logic        m_ur_pend = 1'b0;
    int          m_ucnt = 0;
    int          m_ucnt2 = 0;
    int          m_fs_cnt = 0;
    stereo_t     m_q[$];
    logic        rx_active = 1'b0;
    int          rx_pos = 0;
    logic [63:0] rx_sd = '0;
    logic [63:0] rx_lr = '0;
    stereo_t     rx_exp;
    logic [63:0] cap_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) r_div <= r_div + 3'd1;
    assign bck = r_div[2];

    i2s_tx_ctrl #(.SAMPLE_W(16), .SLOT_BITS(32), .UCNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .bck(bck), .enable(enable),
        .sample_valid(sample_valid), .sample_l(sample_l), .sample_r(sample_r),
        .sample_ready(sample_ready), .lrck(lrck), .sdata(sdata),
        .frame_start(frame_start), .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    i2s_tx_ctrl #(.SAMPLE_W(16), .SLOT_BITS(32), .UCNT_W(2)) u_dut_sat (
        .clk(clk), .reset(reset), .bck(bck), .enable(enable),
        .sample_valid(sample_valid), .sample_l(sample_l), .sample_r(sample_r),
        .sample_ready(ready2), .lrck(lrck2), .sdata(sdata2),
        .frame_start(fs2), .underrun(ur2), .underrun_cnt(ucnt2)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out, got no event expected one at %0t", nm, $time);
    endtask

    function automatic logic [63:0] frame_bits(input stereo_t p);
        return {1'b0, p.l, 15'b0, 1'b0, p.r, 15'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        int n;
        n = 0;
        sample_l     = l;
        sample_r     = r;
        sample_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (sample_ready) break;
            n++;
            if (n > 3000) begin
                timeout_fail("push_accept");
                break;
            end
        end
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic wait_cnt(input int v);
        int n;
        n = 0;
        forever begin
            tick();
            if (m_run && m_cnt == v) break;
            n++;
            if (n > 3000) begin
                timeout_fail("wait_bit_cnt");
                break;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor / reference model, sampled on the falling clk edge
    // ------------------------------------------------------------------
    initial begin : monitor
        logic    fs, fall, rise, acc, ur;
        stereo_t inc;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_prev_bck = 1'b0;
                m_run      = 1'b0;
                m_cnt      = 0;
                m_held     = 1'b0;
                m_ur_pend  = 1'b0;
                m_ucnt     = 0;
                m_ucnt2    = 0;
                rx_active  = 1'b0;
                m_q.delete();
            end else begin
                fall = m_prev_bck && !bck;
                rise = !m_prev_bck && bck;
                fs   = 1'b0;
                if (fall) begin
                    if (!m_run) begin
                        if (enable) begin
                            m_run = 1'b1;
                            m_cnt = 0;
                            fs    = 1'b1;
                        end
                    end else if (m_cnt == 63) begin
                        m_cnt = 0;
                        if (enable) fs = 1'b1;
                        else        m_run = 1'b0;
                    end else begin
                        m_cnt++;
                    end
                end
                check("frame_start", 64'(frame_start), 64'(fs));
                check("sample_ready", 64'(sample_ready), 64'(!m_held));
                check("underrun", 64'(underrun), 64'(m_ur_pend));
                check("underrun_cnt", 64'(underrun_cnt), 64'(m_ucnt));
                check("underrun_cnt_w2", 64'(ucnt2), 64'(m_ucnt2));

                inc.l = sample_l;
                inc.r = sample_r;
                acc   = sample_valid && !m_held;
                ur    = 1'b0;
                if (fs) begin
                    if (m_held) begin
                        rx_exp = m_q.pop_front();
                        m_held = 1'b0;
                    end else if (acc) begin
                        rx_exp = inc;
                    end else begin
                        rx_exp = '0;
                        ur     = 1'b1;
                        if (m_ucnt < 65535) m_ucnt++;
                        if (m_ucnt2 < 3)    m_ucnt2++;
                    end
                    m_fs_cnt++;
                    rx_active = 1'b1;
                    rx_pos    = 0;
                    rx_sd     = '0;
                    rx_lr     = '0;
                end else if (acc) begin
                    m_q.push_back(inc);
                    m_held = 1'b1;
                end
                m_ur_pend = ur;

                if (rise) begin
                    if (rx_active) begin
                        rx_sd = {rx_sd[62:0], sdata};
                        rx_lr = {rx_lr[62:0], lrck};
                        rx_pos++;
                        if (rx_pos == 64) begin
                            check("frame_sdata", rx_sd, frame_bits(rx_exp));
                            check("frame_lrck", rx_lr, 64'h0000_0000_FFFF_FFFF);
                            cap_q.push_back(rx_sd);
                            rx_active = 1'b0;
                        end
                    end else if (!m_run) begin
                        check("idle_pins", 64'({lrck, sdata}), 64'(2'b00));
                    end
                end
                m_prev_bck = bck;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        vec_t vecs[3];
        int   n;
        int   base;

        vecs[0] = '{l: 16'h1234, r: 16'hABCD, exp_frame: 64'h091A0000_55E68000};
        vecs[1] = '{l: 16'h8000, r: 16'h7FFF, exp_frame: 64'h40000000_3FFF8000};
        vecs[2] = '{l: 16'hFFFF, r: 16'h0001, exp_frame: 64'h7FFF8000_00008000};

        // Reset held for 3 clk
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_lrck", 64'(lrck), 64'(1'b0));
        check("rst_sdata", 64'(sdata), 64'(1'b0));
        check("rst_ready", 64'(sample_ready), 64'(1'b1));
        check("rst_underrun", 64'(underrun), 64'(1'b0));
        check("rst_underrun_cnt", 64'(underrun_cnt), 64'(16'h0));

        // Preload one pair while idle, then start playback
        cap_q.delete();
        tick();
        push_pair(16'hA5C3, 16'h0F0F);
        @(negedge clk);
        check("ready_after_push", 64'(sample_ready), 64'(1'b0));
        tick();
        enable = 1'b1;

        // Back-to-back pairs while running; each stalls until a boundary
        for (int i = 0; i < 3; i++) begin
            push_pair(vecs[i].l, vecs[i].r);
        end
        n = 0;
        while (cap_q.size() < 4 && n < 6000) begin
            tick();
            n++;
        end
        if (cap_q.size() < 4) begin
            timeout_fail("first_frames");
        end else begin
            check("frame_a5c3_0f0f", cap_q[0], 64'h52E18000_07878000);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("table_frame_%0d", i), cap_q[i+1], vecs[i].exp_frame);
            end
        end
        check("no_underrun_yet", 64'(underrun_cnt), 64'(16'd0));

        // Starved playback: four mute frames
        n = 0;
        while (m_fs_cnt < 8 && n < 6000) begin
            tick();
            n++;
        end
        if (m_fs_cnt < 8) timeout_fail("underrun_frames");
        @(negedge clk);
        check("underrun_cnt_4", 64'(underrun_cnt), 64'(16'd4));
        check("underrun_cnt_sat3", 64'(ucnt2), 64'(2'd3));

        // Bypass: pair offered exactly in the frame_start clk, buffer empty
        n = 0;
        forever begin
            tick();
            if (m_run && m_cnt == 63 && r_div == 3'd0) break;
            n++;
            if (n > 3000) begin
                timeout_fail("bypass_align");
                break;
            end
        end
        base         = cap_q.size();
        sample_l     = 16'h8001;
        sample_r     = 16'h4321;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        n = 0;
        while (cap_q.size() <= base && n < 3000) begin
            tick();
            n++;
        end
        if (cap_q.size() <= base) timeout_fail("bypass_frame");
        else check("bypass_frame", cap_q[base], 64'h40008000_21908000);
        check("bypass_no_underrun", 64'(underrun_cnt), 64'(16'd4));

        // Deassert enable mid-frame: frame runs to bit 63, then idle
        wait_cnt(40);
        base   = cap_q.size();
        enable = 1'b0;
        n = 0;
        while (m_run && n < 3000) begin
            tick();
            n++;
        end
        if (m_run) timeout_fail("enable_drop_idle");
        check("drop_frame_completed", 64'(cap_q.size()), 64'(base + 1));
        repeat (40) tick();
        @(negedge clk);
        check("idle_lrck", 64'(lrck), 64'(1'b0));
        check("idle_frame_start", 64'(frame_start), 64'(1'b0));

        // Producer fills the buffer while idle, then reset mid-frame
        tick();
        push_pair(16'h1111, 16'h2222);
        tick();
        enable = 1'b1;
        wait_cnt(20);
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_lrck", 64'(lrck), 64'(1'b0));
        check("mid_rst_sdata", 64'(sdata), 64'(1'b0));
        check("mid_rst_ready", 64'(sample_ready), 64'(1'b1));
        check("mid_rst_frame_start", 64'(frame_start), 64'(1'b0));
        check("mid_rst_underrun", 64'(underrun), 64'(1'b0));
        check("mid_rst_underrun_cnt", 64'(underrun_cnt), 64'(16'd0));
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_i2s_tx_ctrl
`default_nettype wire
